// File: rtl/exp1_stim_seq.sv
`default_nettype none
// ============================================================================
//  Module   : exp1_stim_seq
//  Purpose  : Sweeps exp1 inputs abc through 000..111 and captures its five
//             outputs into a 40-bit truth table (auto or manual-step mode).
//  Revision : 1.0  initial release
// ============================================================================
module exp1_stim_seq #(
    parameter int unsigned DWELL_CYCLES = 100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_mode_step,
    input  logic        i_step,
    input  logic        i_l1,
    input  logic        i_l2,
    input  logic        i_x,
    input  logic        i_y,
    input  logic        i_z,
    output logic        o_a,
    output logic        o_b,
    output logic        o_c,
    output logic [2:0]  o_index,
    output logic        o_busy,
    output logic        o_done,
    output logic [39:0] o_truth_table,
    output logic [7:0]  o_valid_mask
);

    localparam logic [15:0] CNT_LAST = 16'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  index_q, index_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [39:0] table_q, table_d;
    logic [7:0]  mask_q,  mask_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            index_q <= 3'd0;
            cnt_q   <= 16'd0;
            table_q <= 40'd0;
            mask_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        mask_d  = mask_q;
        busy_d  = busy_q;
        done_d  = done_q;

        // Abort keeps the captured table so a partial sweep stays readable.
        if (i_abort) begin
            state_d = ST_IDLE;
            index_d = 3'd0;
            cnt_d   = 16'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_d = ST_DRIVE;
                        index_d = 3'd0;
                        cnt_d   = 16'd0;
                        table_d = 40'd0;
                        mask_d  = 8'd0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                ST_DRIVE: begin
                    // Counter saturates at the last dwell cycle; a step pulse
                    // arriving earlier is simply dropped.
                    if (cnt_q == CNT_LAST) begin
                        if (!i_mode_step || i_step) begin
                            state_d = ST_SAMPLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    table_d[5*index_q +: 5] = {i_l1, i_l2, i_x, i_y, i_z};
                    mask_d[index_q]         = 1'b1;
                    if (index_q == 3'd7) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                        index_d = index_q + 3'd1;
                        cnt_d   = 16'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // abc follows the registered index directly, so it is glitch-free.
    assign o_a           = index_q[2];
    assign o_b           = index_q[1];
    assign o_c           = index_q[0];
    assign o_index       = index_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_truth_table = table_q;
    assign o_valid_mask  = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_exp1_stim_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exp1_stim_seq
//  Purpose  : Directed bench for exp1_stim_seq with DWELL_CYCLES = 4 and a
//             behavioural exp1 model closing the loop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exp1_stim_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode_step;
    logic        step;
    logic        a, b, c;
    logic        l1, l2, x, y, z;
    logic [2:0]  index;
    logic        busy;
    logic        done;
    logic [39:0] truth_table;
    logic [7:0]  valid_mask;

    int vectors;
    int miscompares;

    logic [39:0] exp_tbl;

    exp1_stim_seq #(.DWELL_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_mode_step   (mode_step),
        .i_step        (step),
        .i_l1          (l1),
        .i_l2          (l2),
        .i_x           (x),
        .i_y           (y),
        .i_z           (z),
        .o_a           (a),
        .o_b           (b),
        .o_c           (c),
        .o_index       (index),
        .o_busy        (busy),
        .o_done        (done),
        .o_truth_table (truth_table),
        .o_valid_mask  (valid_mask)
    );

    // exp1 stand-in
    assign l1 = a & b;
    assign l2 = a | b;
    assign x  = a ^ b ^ c;
    assign y  = ~c;
    assign z  = a & b & c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        // entries 7..0, each {l1,l2,x,y,z}
        exp_tbl = {5'b11101, 5'b11010, 5'b01000, 5'b01110,
                   5'b01000, 5'b01110, 5'b00100, 5'b00010};
        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        mode_step = 1'b0;
        step      = 1'b0;

        // ---- asynchronous reset, no clock edge involved ----
        #2 rst_n = 1'b0;
        #1;
        check("rst_table", truth_table, 40'd0);
        check("rst_mask",  {32'd0, valid_mask}, 40'd0);
        check("rst_abc",   {37'd0, a, b, c}, 40'd0);
        check("rst_busy",  {39'd0, busy}, 40'd0);
        check("rst_done",  {39'd0, done}, 40'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_mask",  {32'd0, valid_mask}, 40'd0);
        check("idle_abc",   {37'd0, a, b, c}, 40'd0);
        check("idle_busy",  {39'd0, busy}, 40'd0);
        check("idle_table", truth_table, 40'd0);

        // ---- automatic sweep ----
        start = 1'b1;
        tick();
        start = 1'b0;
        check("auto_busy_rise", {39'd0, busy}, 40'd1);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if ((n % 5) == 2) begin
                check("auto_index", {37'd0, index}, 40'(n / 5));
                check("auto_abc",   {37'd0, a, b, c}, 40'(n / 5));
            end
            if (n == 39) check("auto_done_early", {39'd0, done}, 40'd0);
            if (n == 40) begin
                check("auto_done_rise", {39'd0, done}, 40'd1);
                check("auto_busy_fall", {39'd0, busy}, 40'd0);
            end
        end
        check("auto_mask",   {32'd0, valid_mask}, 40'hFF);
        check("auto_table",  truth_table, exp_tbl);
        tick();
        check("done_abc",    {37'd0, a, b, c}, 40'd7);

        // ---- restart from DONE in manual-step mode ----
        mode_step = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_mask",  {32'd0, valid_mask}, 40'd0);
        check("restart_table", truth_table, 40'd0);
        check("restart_busy",  {39'd0, busy}, 40'd1);
        check("restart_done",  {39'd0, done}, 40'd0);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        check("step_early_ignored", {32'd0, valid_mask}, 40'd0);
        check("step_hold_index",    {37'd0, index}, 40'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_in_sample", {32'd0, valid_mask}, 40'd0);
        tick();
        check("step_capture_mask",  {32'd0, valid_mask}, 40'h01);
        check("step_capture_index", {37'd0, index}, 40'd1);
        for (int k = 1; k < 8; k++) begin
            repeat (4) tick();
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
        end
        check("step_done",  {39'd0, done}, 40'd1);
        check("step_mask",  {32'd0, valid_mask}, 40'hFF);
        check("step_table", truth_table, exp_tbl);

        // ---- abort after three entries ----
        mode_step = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_run_mask_clear", {32'd0, valid_mask}, 40'd0);
        repeat (16) tick();
        check("abort_pre_mask", {32'd0, valid_mask}, 40'h07);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",  {39'd0, busy}, 40'd0);
        check("abort_done",  {39'd0, done}, 40'd0);
        check("abort_index", {37'd0, index}, 40'd0);
        check("abort_abc",   {37'd0, a, b, c}, 40'd0);
        check("abort_mask",  {32'd0, valid_mask}, 40'h07);
        check("abort_table", truth_table, {25'd0, exp_tbl[14:0]});
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("start_abort_busy", {39'd0, busy}, 40'd0);
        check("start_abort_mask", {32'd0, valid_mask}, 40'h07);

        // ---- start while busy, then reset mid-sweep ----
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("busy_start_index", {37'd0, index}, 40'd2);
        repeat (15) tick();
        check("mid_index", {37'd0, index}, 40'd5);
        check("mid_mask",  {32'd0, valid_mask}, 40'h1F);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_table", truth_table, 40'd0);
        check("mid_rst_mask",  {32'd0, valid_mask}, 40'd0);
        check("mid_rst_abc",   {37'd0, a, b, c}, 40'd0);
        check("mid_rst_index", {37'd0, index}, 40'd0);
        check("mid_rst_busy",  {39'd0, busy}, 40'd0);
        check("mid_rst_done",  {39'd0, done}, 40'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
